// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin N-master front end sequencing fixed-latency IO bus accesses.
// Define IO_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module io_bus_arbiter #(
  parameter int N_MST = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 4,
  parameter int LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_MST-1:0]    m_req,
  input  logic [N_MST-1:0]    m_we,
  input  logic [N_MST*AW-1:0] m_addr,
  input  logic [N_MST*DW-1:0] m_wdata,
  output logic [N_MST-1:0]    m_ack,
  output logic [DW-1:0]       m_rdata,
  output logic [N_MST-1:0]    grant,
  output logic                bus_bc,
  output logic [AW-1:0]       bus_addr,
  output logic [CW-1:0]       bus_ctrl,
  output logic [DW-1:0]       bus_wdata,
  output logic                bus_data_oe,
  input  logic [DW-1:0]       bus_rdata
);
  localparam int PW = N_MST > 1 ? $clog2(N_MST) : 1;
  localparam int CNTW = LAT > 1 ? $clog2(LAT) : 1;
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, win_d, sel;
  logic [N_MST-1:0] grant_q, grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic we_q, we_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2*N_MST-1:0] rot;
  // Rotate requests so bit 0 is the master at ptr; the lowest set bit wins.
  always_comb begin
    rot = {m_req, m_req} >> ptr_q;
    sel = '0;
    for (int k = N_MST - 1; k >= 0; k--)
      if (rot[k]) sel = PW'((int'(ptr_q) + k) % N_MST);
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    grant_d = grant_q;
    addr_d = addr_q;
    we_d = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (|m_req) begin
        state_d = ACCESS;
        win_d = sel;
        grant_d = N_MST'(1) << sel;
        addr_d = m_addr[sel*AW +: AW];
        we_d = m_we[sel];
        wdata_d = m_wdata[sel*DW +: DW];
        cnt_d = CNTW'(LAT - 1);
      end
    end else if (state_q == ACCESS) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = DONE;
        rdata_d = we_q ? rdata_q : bus_rdata;
      end
    end else begin
      state_d = IDLE;
      grant_d = '0;
`ifdef IO_ARB_FIXED_PRIO_EN
      ptr_d = '0;
`else
      ptr_d = (win_q == PW'(N_MST - 1)) ? '0 : win_q + 1'b1;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      win_q <= '0;
      grant_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      grant_q <= grant_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus_bc = state_q == ACCESS;
  assign bus_ctrl = bus_bc ? (we_q ? CW'(2) : CW'(1)) : '0;
  assign bus_data_oe = bus_bc & we_q;
  assign bus_addr = addr_q;
  assign bus_wdata = wdata_q;
  assign grant = grant_q;
  assign m_ack = (state_q == DONE) ? grant_q : '0;
  assign m_rdata = rdata_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed checks of arbitration, bus sequencing, ack timing and reset abort.
module tb_io_bus_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] m_req = '0, m_we = '0, m_ack, grant;
  logic [63:0] m_addr = '0, m_wdata = '0;
  logic [31:0] m_rdata, bus_addr, bus_wdata, bus_rdata = '0;
  logic [3:0] bus_ctrl;
  logic bus_bc, bus_data_oe;
  int n_chk = 0, n_bad = 0;
  logic [1:0] exp_g [4];

  io_bus_arbiter dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .grant(grant), .bus_bc(bus_bc), .bus_addr(bus_addr),
    .bus_ctrl(bus_ctrl), .bus_wdata(bus_wdata), .bus_data_oe(bus_data_oe), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
`ifdef IO_ARB_FIXED_PRIO_EN
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_bc", bus_bc, 0);
    chk("rst_ctrl", bus_ctrl, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_oe", bus_data_oe, 0);
    // master 0 read
    m_req = 2'b01; m_we = 2'b00; m_addr[31:0] = 32'h0000_0040; bus_rdata = 32'h1234_5678;
    tick();
    chk("rd_a1_bc", bus_bc, 1);
    chk("rd_a1_ctrl", bus_ctrl, 4'b0001);
    chk("rd_a1_addr", bus_addr, 32'h40);
    chk("rd_a1_grant", grant, 2'b01);
    chk("rd_a1_oe", bus_data_oe, 0);
    chk("rd_a1_ack", m_ack, 0);
    tick();
    chk("rd_a2_bc", bus_bc, 1);
    chk("rd_a2_ctrl", bus_ctrl, 4'b0001);
    chk("rd_a2_ack", m_ack, 0);
    tick();
    chk("rd_done_ack", m_ack, 2'b01);
    chk("rd_done_bc", bus_bc, 0);
    chk("rd_done_ctrl", bus_ctrl, 0);
    chk("rd_rdata", m_rdata, 32'h1234_5678);
    m_req = 2'b00;
    tick();
    chk("rd_idle_ack", m_ack, 0);
    chk("rd_idle_grant", grant, 0);
    // master 1 write
    m_req = 2'b10; m_we = 2'b10; m_addr[63:32] = 32'hFFFF_F060; m_wdata[63:32] = 32'hA5;
    bus_rdata = 32'hDEAD_BEEF;
    tick();
    chk("wr_a1_ctrl", bus_ctrl, 4'b0010);
    chk("wr_a1_oe", bus_data_oe, 1);
    chk("wr_a1_wdata", bus_wdata, 32'hA5);
    chk("wr_a1_addr", bus_addr, 32'hFFFF_F060);
    chk("wr_a1_grant", grant, 2'b10);
    m_addr[63:32] = 32'h0; m_wdata[63:32] = 32'h0;
    tick();
    chk("wr_a2_ctrl", bus_ctrl, 4'b0010);
    chk("wr_a2_oe", bus_data_oe, 1);
    chk("wr_a2_addr", bus_addr, 32'hFFFF_F060);
    tick();
    chk("wr_done_ack", m_ack, 2'b10);
    chk("wr_done_oe", bus_data_oe, 0);
    chk("wr_rdata_kept", m_rdata, 32'h1234_5678);
    m_req = 2'b00; m_we = 2'b00;
    tick();
    // both masters requesting continuously
    do_reset();
    m_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("rr%0d_grant", t), grant, exp_g[t]);
      chk($sformatf("rr%0d_bc", t), bus_bc, 1);
      tick();
      tick();
      chk($sformatf("rr%0d_ack", t), m_ack, exp_g[t]);
      tick();
      chk($sformatf("rr%0d_gap_bc", t), bus_bc, 0);
      chk($sformatf("rr%0d_ack_width", t), m_ack, 0);
    end
    m_req = 2'b00;
    tick();
    // master 0 drops req during the first access cycle
    do_reset();
    m_req = 2'b01;
    tick();
    m_req = 2'b00;
    chk("drop_grant", grant, 2'b01);
    tick();
    tick();
    chk("drop_ack", m_ack, 2'b01);
    tick();
    chk("drop_ack_once", m_ack, 0);
    tick();
    chk("drop_no_new_bc", bus_bc, 0);
    // reset abort in the second access cycle (ptr now points at master 1)
    m_req = 2'b10;
    tick();
    chk("abort_grant", grant, 2'b10);
    tick();
    chk("abort_a2_bc", bus_bc, 1);
    rst = 1'b1; m_req = 2'b00;
    tick();
    rst = 1'b0;
    chk("abort_bc", bus_bc, 0);
    chk("abort_grant0", grant, 0);
    chk("abort_ack", m_ack, 0);
    begin
      logic [1:0] seen;
      seen = '0;
      for (int t = 0; t < 4; t++) begin
        tick();
        seen |= m_ack;
      end
      chk("abort_no_ack", seen, 0);
    end
    m_req = 2'b11;
    tick();
    chk("post_abort_grant", grant, 2'b01);
    begin
      int w;
      w = 0;
      while (m_ack == 2'b00 && w < 10) begin
        tick();
        w++;
      end
      chk("post_abort_ack", m_ack, 2'b01);
      chk("post_abort_lat", w, 2);
    end
    m_req = 2'b00;
    tick();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
